coin_credit_accumulator: RTL and testbench

//  Upstream front end of the vending datapath. Accepts single-cycle coin and selection events.

---
 rtl/coin_credit_accumulator.sv | 126 ++++++++++++
 tb/tb_coin_credit_accumulator.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_credit_accumulator.sv
// Credit front end of the vending datapath: accumulates coins and hands {amount, selection} to the
// vending stage, or returns the credit through the refund handshake on cancel or inactivity.
module coin_credit_accumulator #(
    parameter int AMT_W          = 8,
    parameter int MAX_CREDIT     = 200,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             coin_valid,
    input  logic [1:0]       coin_type,
    input  logic             sel_valid,
    input  logic [2:0]       sel_code,
    input  logic             cancel,
    output logic             vend_valid,
    input  logic             vend_ready,
    output logic [AMT_W-1:0] amount,
    output logic [2:0]       selection,
    output logic             refund_valid,
    input  logic             refund_ready,
    output logic [AMT_W-1:0] refund_amount,
    output logic             coin_reject
);

    // state     | meaning
    // S_IDLE    | no credit held; first accepted coin starts a session
    // S_CREDIT  | credit held; coins add, sel requests, cancel/timeout refunds
    // S_REQUEST | vend_valid up, amount/selection frozen until vend_ready
    // S_REFUND  | refund_valid up, refund_amount frozen until refund_ready
    typedef enum logic [1:0] {S_IDLE, S_CREDIT, S_REQUEST, S_REFUND} state_t;

    localparam int               TMR_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [AMT_W:0]   MAX_SUM  = (AMT_W + 1)'(MAX_CREDIT);

    state_t            state_q, state_d;
    logic [AMT_W-1:0]  credit_q;
    logic [TMR_W-1:0]  timer_q;
    logic [2:0]        selection_q;
    logic              coin_reject_q;

    logic [AMT_W:0]    coin_value;
    logic [AMT_W:0]    coin_sum;
    logic              coin_accept;
    logic              timeout;
    logic              vend_done;
    logic              refund_done;

    always_comb begin
        coin_value = '0;
        case (coin_type)
            2'b00:   coin_value = (AMT_W + 1)'(5);
            2'b01:   coin_value = (AMT_W + 1)'(10);
            2'b10:   coin_value = (AMT_W + 1)'(25);
            default: coin_value = (AMT_W + 1)'(100);
        endcase
    end

    // One extra bit on the sum so an over-limit coin can never wrap into range.
    assign coin_sum    = {1'b0, credit_q} + coin_value;
    assign coin_accept = coin_valid && (coin_sum <= MAX_SUM)
                         && (state_q == S_IDLE || state_q == S_CREDIT);
    assign timeout     = (state_q == S_CREDIT) && !coin_accept && (timer_q == TMR_LAST);
    assign vend_done   = (state_q == S_REQUEST) && vend_ready;
    assign refund_done = (state_q == S_REFUND) && refund_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (coin_accept) state_d = S_CREDIT;
            S_CREDIT: begin
                if (cancel || timeout) begin
                    state_d = S_REFUND;
                end else if (sel_valid) begin
                    state_d = S_REQUEST;
                end
            end
            S_REQUEST: if (vend_ready) state_d = S_IDLE;
            S_REFUND:  if (refund_ready) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_q      <= '0;
            timer_q       <= '0;
            selection_q   <= '0;
            coin_reject_q <= 1'b0;
        end else begin
            coin_reject_q <= coin_valid && !coin_accept;
            if (vend_done || refund_done) begin
                credit_q <= '0;
            end else if (coin_accept) begin
                credit_q <= coin_sum[AMT_W-1:0];
            end
            // Staying in CREDIT without a coin implies timer_q < TMR_LAST, so no saturation.
            if (state_d != S_CREDIT || coin_accept) begin
                timer_q <= '0;
            end else begin
                timer_q <= timer_q + TMR_W'(1);
            end
            if (state_q == S_CREDIT && state_d == S_REQUEST) begin
                selection_q <= sel_code;
            end
        end
    end

    always_comb begin
        vend_valid    = (state_q == S_REQUEST);
        refund_valid  = (state_q == S_REFUND);
        amount        = credit_q;
        refund_amount = credit_q;
        selection     = selection_q;
        coin_reject   = coin_reject_q;
    end

endmodule

// File: tb/tb_coin_credit_accumulator.sv
// Bench for coin_credit_accumulator: session-level model compared every cycle, plus directed
// scenarios with hand-computed literal expectations.
module tb_coin_credit_accumulator;

    localparam int AMT_W   = 8;
    localparam int MAX_CR  = 200;
    localparam int TIMEOUT = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       coin_valid = 1'b0;
    logic [1:0] coin_type = 2'b00;
    logic       sel_valid = 1'b0;
    logic [2:0] sel_code = 3'd0;
    logic       cancel = 1'b0;
    logic       vend_ready = 1'b0;
    logic       refund_ready = 1'b0;
    logic             vend_valid;
    logic [AMT_W-1:0] amount;
    logic [2:0]       selection;
    logic             refund_valid;
    logic [AMT_W-1:0] refund_amount;
    logic             coin_reject;

    int checks = 0;
    int errors = 0;

    coin_credit_accumulator #(
        .AMT_W(AMT_W), .MAX_CREDIT(MAX_CR), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .coin_valid(coin_valid), .coin_type(coin_type),
        .sel_valid(sel_valid), .sel_code(sel_code), .cancel(cancel),
        .vend_valid(vend_valid), .vend_ready(vend_ready),
        .amount(amount), .selection(selection),
        .refund_valid(refund_valid), .refund_ready(refund_ready),
        .refund_amount(refund_amount), .coin_reject(coin_reject)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Session model: mode 0=idle 1=holding credit 2=vend request 3=refund request.
    int coin_cents[4] = '{5, 10, 25, 100};
    int m_mode = 0;
    int m_credit = 0;
    int m_sel = 0;
    int m_idle_run = 0;
    int m_reject = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_credit = 0; m_sel = 0; m_idle_run = 0; m_reject = 0;
        end else begin
            int  v;
            bit  took;
            v      = coin_cents[coin_type];
            took   = 0;
            m_reject = 0;
            if (coin_valid) begin
                if ((m_mode == 0 || m_mode == 1) && (m_credit + v <= MAX_CR)) begin
                    m_credit += v;
                    took = 1;
                end else begin
                    m_reject = 1;
                end
            end
            case (m_mode)
                0: if (took) begin m_mode = 1; m_idle_run = 0; end
                1: begin
                    m_idle_run = took ? 0 : m_idle_run + 1;
                    if (cancel || m_idle_run == TIMEOUT) begin
                        m_mode = 3;
                    end else if (sel_valid) begin
                        m_sel  = sel_code;
                        m_mode = 2;
                    end
                end
                2: if (vend_ready) begin m_mode = 0; m_credit = 0; end
                default: if (refund_ready) begin m_mode = 0; m_credit = 0; end
            endcase
        end
    end

    always @(posedge clk) begin
        #1;
        chk("vend_valid", vend_valid, m_mode == 2);
        chk("refund_valid", refund_valid, m_mode == 3);
        chk("amount", amount, m_credit);
        chk("refund_amount", refund_amount, m_credit);
        chk("selection", selection, m_sel);
        chk("coin_reject", coin_reject, m_reject);
        chk("valid_exclusive", vend_valid && refund_valid, 0);
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic put_coin(input logic [1:0] t);
        coin_valid = 1'b1; coin_type = t;
        tick();
        coin_valid = 1'b0;
    endtask

    task automatic put_sel(input logic [2:0] c);
        sel_valid = 1'b1; sel_code = c;
        tick();
        sel_valid = 1'b0;
    endtask

    task automatic put_cancel();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
    endtask

    task automatic drain_refund();
        refund_ready = 1'b1;
        tick();
        refund_ready = 1'b0;
    endtask

    initial begin
        tick(3);
        chk("reset_vend_valid", vend_valid, 0);
        chk("reset_refund_valid", refund_valid, 0);
        chk("reset_amount", amount, 0);
        chk("reset_coin_reject", coin_reject, 0);
        rst_n = 1'b1;
        tick();

        // 25 + 25 + 10 then selection 6 with the vending stage ready
        vend_ready = 1'b1;
        put_coin(2'b10); put_coin(2'b10); put_coin(2'b01);
        chk("t1_credit", amount, 60);
        put_sel(3'd6);
        chk("t1_vend_valid", vend_valid, 1);
        chk("t1_amount", amount, 60);
        chk("t1_selection", selection, 6);
        tick();
        chk("t1_idle_vend_valid", vend_valid, 0);
        chk("t1_idle_amount", amount, 0);
        vend_ready = 1'b0;

        // build 195, then 5 reaches exactly the cap, next 5 is rejected
        put_coin(2'b11); put_coin(2'b10); put_coin(2'b10); put_coin(2'b10);
        put_coin(2'b01); put_coin(2'b01);
        chk("t2_credit195", amount, 195);
        put_coin(2'b00);
        chk("t2_credit200", amount, 200);
        chk("t2_no_reject", coin_reject, 0);
        put_coin(2'b00);
        chk("t2_reject", coin_reject, 1);
        chk("t2_credit_held", amount, 200);
        tick();
        chk("t2_reject_one_cycle", coin_reject, 0);
        put_cancel();
        drain_refund();

        // 35 cancelled with the refund path stalled for 3 cycles
        put_coin(2'b10); put_coin(2'b01);
        put_cancel();
        for (int i = 0; i < 3; i++) begin
            chk("t3_refund_valid", refund_valid, 1);
            chk("t3_refund_amount", refund_amount, 35);
            tick();
        end
        drain_refund();
        chk("t3_cleared_valid", refund_valid, 0);
        chk("t3_cleared_amount", refund_amount, 0);

        // coin and selection during a stalled request
        put_coin(2'b01);
        put_sel(3'd3);
        coin_valid = 1'b1; coin_type = 2'b01; sel_valid = 1'b1; sel_code = 3'd2;
        tick();
        coin_valid = 1'b0; sel_valid = 1'b0;
        chk("t4_reject", coin_reject, 1);
        chk("t4_amount", amount, 10);
        chk("t4_selection", selection, 3);
        tick(2);
        chk("t4_amount_held", amount, 10);
        vend_ready = 1'b1;
        tick();
        vend_ready = 1'b0;
        chk("t4_done", vend_valid, 0);

        // inactivity timeout after 100
        put_coin(2'b11);
        tick(TIMEOUT - 1);
        chk("t5_no_refund_yet", refund_valid, 0);
        tick();
        chk("t5_timeout_refund", refund_valid, 1);
        chk("t5_timeout_amount", refund_amount, 100);
        drain_refund();

        // coin in the timeout cycle restarts the idle window
        put_coin(2'b11);
        tick(TIMEOUT - 1);
        put_coin(2'b01);
        chk("t5_coin_saves", refund_valid, 0);
        chk("t5_credit110", amount, 110);
        tick(TIMEOUT - 1);
        chk("t5_still_credit", refund_valid, 0);
        put_cancel();
        drain_refund();

        // cancel + sel + coin together: coin counts, cancel wins
        put_coin(2'b00);
        coin_valid = 1'b1; coin_type = 2'b01; cancel = 1'b1; sel_valid = 1'b1; sel_code = 3'd7;
        tick();
        coin_valid = 1'b0; cancel = 1'b0; sel_valid = 1'b0;
        chk("t7_refund_valid", refund_valid, 1);
        chk("t7_refund_amount", refund_amount, 15);
        chk("t7_vend_valid", vend_valid, 0);
        chk("t7_sel_dropped", selection, 3);
        drain_refund();

        // coin with sel: request includes the coin
        put_coin(2'b10);
        vend_ready = 1'b1;
        coin_valid = 1'b1; coin_type = 2'b10; sel_valid = 1'b1; sel_code = 3'd4;
        tick();
        coin_valid = 1'b0; sel_valid = 1'b0;
        chk("t8_amount", amount, 50);
        chk("t8_selection", selection, 4);
        tick();
        vend_ready = 1'b0;

        // asynchronous reset mid-request
        put_coin(2'b00);
        put_sel(3'd1);
        chk("t6_pre_vend_valid", vend_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_vend_valid", vend_valid, 0);
        chk("t6_amount", amount, 0);
        chk("t6_selection", selection, 0);
        chk("t6_refund_valid", refund_valid, 0);
        tick();
        rst_n = 1'b1;
        tick();
        put_sel(3'd5);
        chk("t6_sel_ignored_vv", vend_valid, 0);
        chk("t6_sel_ignored_sel", selection, 0);
        put_cancel();
        chk("t6_cancel_ignored", refund_valid, 0);
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
